// File: rtl/data_memory_sized.sv
// Data memory for the MEM stage of the pipelined MIPS core.
// Supports byte/half/word stores and sign- or zero-extended loads, a registered
// read port with a Ready strobe, and a Fault strobe for misaligned requests.
// After reset a clear FSM walks the array one word per clock. It preloads the
// 7-segment digit table into words 0..15, and Busy stays high until the walk ends.
module data_memory_sized #(
  parameter int          RAM_SIZE     = 256,
  parameter int          RAM_SIZE_BIT = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h0,
  parameter bit          TABLE_EN     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address_i,
  input  logic [31:0] write_data_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [1:0]  mem_size_i,
  input  logic        mem_signed_i,
  output logic [31:0] read_data_o,
  output logic        ready_o,
  output logic        fault_o,
  output logic        busy_o
);

  typedef enum logic {S_INIT, S_IDLE} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [RAM_SIZE_BIT-1:0] LAST_WORD = RAM_SIZE_BIT'(RAM_SIZE - 1);

  // 7-segment patterns for hex digits 0..F (segment a in bit 0).
  function automatic logic [7:0] seg_code(input logic [3:0] digit);
    case (digit)
      4'h0: seg_code = 8'h3F;  4'h1: seg_code = 8'h06;
      4'h2: seg_code = 8'h5B;  4'h3: seg_code = 8'h4F;
      4'h4: seg_code = 8'h66;  4'h5: seg_code = 8'h6D;
      4'h6: seg_code = 8'h7D;  4'h7: seg_code = 8'h07;
      4'h8: seg_code = 8'h7F;  4'h9: seg_code = 8'h6F;
      4'hA: seg_code = 8'h77;  4'hB: seg_code = 8'h7C;
      4'hC: seg_code = 8'h39;  4'hD: seg_code = 8'h5E;
      4'hE: seg_code = 8'h79;  default: seg_code = 8'h71;
    endcase
  endfunction

  state_t                  state_q;
  logic [RAM_SIZE_BIT-1:0] cnt_q;
  logic [31:0]             read_data_q;
  logic                    ready_q;
  logic                    fault_q;
  logic                    busy_q;

  logic [31:0] mem_q [RAM_SIZE];

  // Request decode
  logic [RAM_SIZE_BIT-1:0] word_idx;
  logic                    in_range;
  logic                    misaligned;
  logic                    access_ok;
  logic [31:0]             rd_word;
  logic [7:0]              lane_byte;
  logic [15:0]             lane_half;
  logic [31:0]             load_d;

  // Init value
  logic [31:0] cnt_ext;
  logic [31:0] init_val;

  // Memory write port, shared by the init FSM and stores
  logic                    mem_we;
  logic [RAM_SIZE_BIT-1:0] mem_widx;
  logic [31:0]             mem_wdata;
  logic [3:0]              mem_be;

  // Decode the address, size and alignment of the current request and extract the load lane.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    word_idx   = address_i[RAM_SIZE_BIT+1:2] - BASE_ADDR[RAM_SIZE_BIT+1:2];
    in_range   = (address_i[31:RAM_SIZE_BIT+2] == BASE_ADDR[31:RAM_SIZE_BIT+2]);
    misaligned = 1'b0;
    case (mem_size_i)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = address_i[0];
      SZ_WORD: misaligned = (address_i[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
    access_ok = in_range && !misaligned;

    rd_word   = mem_q[word_idx];
    lane_byte = rd_word[{address_i[1:0], 3'b000} +: 8];
    lane_half = rd_word[{address_i[1], 4'b0000} +: 16];

    load_d = '0;
    if (access_ok) begin
      case (mem_size_i)
        SZ_BYTE: load_d = {{24{mem_signed_i & lane_byte[7]}}, lane_byte};
        SZ_HALF: load_d = {{16{mem_signed_i & lane_half[15]}}, lane_half};
        default: load_d = rd_word;
      endcase
    end
  end

  // Select who drives the write port: the clear walk during INIT, aligned in-range stores in IDLE.
  always_comb begin
    cnt_ext  = 32'(cnt_q);
    init_val = (TABLE_EN && (cnt_ext < 32'd16)) ? {24'h0, seg_code(cnt_q[3:0])} : 32'h0;

    mem_we    = 1'b0;
    mem_widx  = word_idx;
    mem_wdata = write_data_i;
    mem_be    = 4'b0000;
    if (state_q == S_INIT) begin
      mem_we    = 1'b1;
      mem_widx  = cnt_q;
      mem_wdata = init_val;
      mem_be    = 4'b1111;
    end else begin
      mem_we = mem_write_i && access_ok;
      case (mem_size_i)
        SZ_BYTE: begin
          mem_wdata = {4{write_data_i[7:0]}};
          mem_be    = 4'b0001 << address_i[1:0];
        end
        SZ_HALF: begin
          mem_wdata = {2{write_data_i[15:0]}};
          mem_be    = address_i[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          mem_wdata = write_data_i;
          mem_be    = 4'b1111;
        end
      endcase
    end
  end

  // Byte-lane write into the storage array.
  // NOTE: the array has no reset; the init FSM clears it word by word instead.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (mem_be[lane]) mem_q[mem_widx][lane*8 +: 8] <= mem_wdata[lane*8 +: 8];
      end
    end
  end

  // Control FSM: clear walk, then service requests with registered result and strobes.
  // NOTE: non-blocking assignments keep the old word visible to a same-cycle load (read-before-write).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_INIT;
      cnt_q       <= '0;
      read_data_q <= '0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      case (state_q)
        S_INIT: begin
          ready_q <= 1'b0;
          fault_q <= 1'b0;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST_WORD) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          ready_q <= mem_read_i;
          fault_q <= (mem_read_i || mem_write_i) && misaligned;
          if (mem_read_i) read_data_q <= load_d;
        end
      endcase
    end
  end

  assign read_data_o = read_data_q;
  assign ready_o     = ready_q;
  assign fault_o     = fault_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_data_memory_sized.sv
// Self-checking bench for data_memory_sized: init timing, directed vectors,
// reset during init, and randomized traffic against a word-array reference model.
module tb_data_memory_sized;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address_i;
  logic [31:0] write_data_i;
  logic        mem_read_i;
  logic        mem_write_i;
  logic [1:0]  mem_size_i;
  logic        mem_signed_i;
  logic [31:0] read_data_o;
  logic        ready_o;
  logic        fault_o;
  logic        busy_o;

  data_memory_sized dut (
    .clk          (clk),
    .rst          (rst),
    .address_i    (address_i),
    .write_data_i (write_data_i),
    .mem_read_i   (mem_read_i),
    .mem_write_i  (mem_write_i),
    .mem_size_i   (mem_size_i),
    .mem_signed_i (mem_signed_i),
    .read_data_o  (read_data_o),
    .ready_o      (ready_o),
    .fault_o      (fault_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  localparam logic [7:0] SEG [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                      8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: plain array of words, byte addresses 0..1023.
  int unsigned mem_m [256];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wd;
    logic        rd;
    logic        wr;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] exp_d;
    logic        exp_r;
    logic        exp_f;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic rd,
                       input logic wr, input logic [1:0] sz, input logic sg);
    address_i    = a;
    write_data_i = wd;
    mem_read_i   = rd;
    mem_write_i  = wr;
    mem_size_i   = sz;
    mem_signed_i = sg;
  endtask

  function automatic bit is_bad(input logic [31:0] a, input logic [1:0] sz);
    return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz,
                                             input logic sg);
    int unsigned w, v, sh;
    if (is_bad(a, sz) || a >= 32'd1024) return 32'h0;
    w  = mem_m[a / 4];
    sh = 8 * (a % 4);
    case (sz)
      2'd0: begin
        v = (w >> sh) & 32'hFF;
        if (sg && v >= 128) v = v - 256;
      end
      2'd1: begin
        v = (w >> sh) & 32'hFFFF;
        if (sg && v >= 32768) v = v - 65536;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz);
    int unsigned mask, sh;
    if (is_bad(a, sz) || a >= 32'd1024) return;
    sh   = 8 * (a % 4);
    mask = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
    mask = mask << sh;
    mem_m[a / 4] = (mem_m[a / 4] & ~mask) | ((wd << sh) & mask);
  endtask

  task automatic model_init();
    for (int i = 0; i < 256; i++) mem_m[i] = (i < 16) ? 32'(SEG[i]) : 32'h0;
  endtask

  // Count clocks until Busy falls; optionally fire random requests that must be ignored.
  task automatic wait_init(input string tag, input bit noisy);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (noisy) begin
        check("init_quiet", {30'h0, ready_o, fault_o}, 32'h0);
        drive($urandom_range(0, 255), $urandom, 1'($urandom), 1'($urandom),
              2'($urandom), 1'($urandom));
      end
    end while (busy_o && n < 400);
    drive(0, 0, 0, 0, 0, 0);
    check(tag, n, 256);
  endtask

  task automatic vec(input logic [31:0] a, input logic [31:0] wd, input logic rd,
                     input logic wr, input logic [1:0] sz, input logic sg,
                     input logic [31:0] d, input logic r, input logic f);
    vecs.push_back('{a, wd, rd, wr, sz, sg, d, r, f});
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);

    // Reset state and first init
    @(posedge clk);
    #1;
    check("rst_busy", 32'(busy_o), 32'h1);
    check("rst_ready", 32'(ready_o), 32'h0);
    check("rst_fault", 32'(fault_o), 32'h0);
    check("rst_rdata", read_data_o, 32'h0);
    rst = 1'b0;
    wait_init("init_len", 1'b0);

    // Directed vectors:  addr    wdata         rd wr sz sg  exp_d          rdy flt
    vec(32'h000, 32'h0,          1, 0, 2, 0, 32'h0000_003F, 1, 0);
    vec(32'h03C, 32'h0,          1, 0, 2, 0, 32'h0000_0071, 1, 0);
    vec(32'h040, 32'h0,          1, 0, 2, 0, 32'h0000_0000, 1, 0);
    vec(32'h080, 32'h1122_3344,  0, 1, 2, 0, 32'h0,         0, 0);
    vec(32'h081, 32'h0000_00AA,  0, 1, 0, 0, 32'h0,         0, 0);
    vec(32'h080, 32'h0,          1, 0, 2, 0, 32'h1122_AA44, 1, 0);
    vec(32'h082, 32'h0,          1, 0, 1, 1, 32'h0000_1122, 1, 0);
    vec(32'h081, 32'h0,          1, 0, 0, 1, 32'hFFFF_FFAA, 1, 0);
    vec(32'h081, 32'h0,          1, 0, 0, 0, 32'h0000_00AA, 1, 0);
    vec(32'h080, 32'h0,          1, 0, 1, 0, 32'h0000_AA44, 1, 0);
    vec(32'h080, 32'h0,          1, 0, 1, 1, 32'hFFFF_AA44, 1, 0);
    vec(32'h083, 32'h0,          1, 0, 0, 1, 32'h0000_0011, 1, 0);
    vec(32'h082, 32'h0,          1, 0, 2, 0, 32'h0000_0000, 1, 1);
    vec(32'h083, 32'h0000_5555,  0, 1, 1, 0, 32'h0,         0, 1);
    vec(32'h080, 32'h0,          1, 0, 3, 0, 32'h0000_0000, 1, 1);
    vec(32'h080, 32'h0,          1, 0, 2, 0, 32'h1122_AA44, 1, 0);
    vec(32'h400, 32'hDEAD_BEEF,  0, 1, 2, 0, 32'h0,         0, 0);
    vec(32'h400, 32'h0,          1, 0, 2, 0, 32'h0000_0000, 1, 0);
    vec(32'h000, 32'h0,          1, 0, 2, 0, 32'h0000_003F, 1, 0);
    vec(32'h3FC, 32'hCAFE_F00D,  0, 1, 2, 0, 32'h0,         0, 0);
    vec(32'h3FC, 32'h0,          1, 0, 2, 0, 32'hCAFE_F00D, 1, 0);
    vec(32'h090, 32'h0000_0005,  1, 1, 2, 0, 32'h0000_0000, 1, 0);
    vec(32'h090, 32'h0,          1, 0, 2, 0, 32'h0000_0005, 1, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].addr, vecs[i].wd, vecs[i].rd, vecs[i].wr, vecs[i].sz, vecs[i].sg);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_ready", i), 32'(ready_o), 32'(vecs[i].exp_r));
      check($sformatf("vec%0d_fault", i), 32'(fault_o), 32'(vecs[i].exp_f));
      if (vecs[i].exp_r) check($sformatf("vec%0d_data", i), read_data_o, vecs[i].exp_d);
    end
    drive(0, 0, 0, 0, 0, 0);

    // Reset in the middle of init, with requests fired during the restarted init
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("mid_busy", 32'(busy_o), 32'h1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy_o), 32'h1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_init("reinit_len", 1'b1);

    // Randomized traffic against the reference model
    model_init();
    begin
      logic [31:0] a, wd, exp_d, last_d;
      logic        rd, wr, sg;
      logic [1:0]  sz;
      int          r;
      last_d = read_data_o;
      for (int it = 0; it < 400; it++) begin
        r = $urandom_range(0, 9);
        if (r < 6)      a = $urandom_range(0, 31);
        else if (r < 9) a = $urandom_range(0, 1023);
        else            a = $urandom;
        wd = $urandom;
        rd = 1'($urandom);
        wr = 1'($urandom);
        sg = 1'($urandom);
        sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        exp_d = rd ? model_load(a, sz, sg) : last_d;
        if (wr) model_store(a, wd, sz);
        drive(a, wd, rd, wr, sz, sg);
        @(posedge clk);
        #1;
        check("rnd_ready", 32'(ready_o), 32'(rd));
        check("rnd_fault", 32'(fault_o), 32'((rd || wr) && is_bad(a, sz)));
        check("rnd_data", read_data_o, exp_d);
        last_d = exp_d;
      end
      drive(0, 0, 0, 0, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
